// File: rtl/core_mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : core_mem_arbiter_if
// Description : Bundle of the fetch port, load/store port and single-ported
//               memory port that meet at core_mem_arbiter.
//               slave  - arbiter view (takes requests, drives grants/memory)
//               master - environment view (core requesters + memory)
//               Fetch : if_req, if_addr -> if_gnt, if_rvalid, if_rdata, stall_if
//               Data  : d_req, d_we, d_addr, d_wdata, d_be -> d_gnt, d_rvalid,
//                       d_rdata
//               Memory: mem_en, mem_we, mem_be, mem_addr, mem_wdata <- mem_rdata
// Revision    : 1.0 - initial release
// ============================================================================
interface core_mem_arbiter_if #(
  parameter int BUS_WIDTH  = 32,
  parameter int DATA_WIDTH = 32
);
  localparam int BE_WIDTH = DATA_WIDTH / 8;

  // Instruction-fetch port
  logic                  if_req;
  logic [BUS_WIDTH-1:0]  if_addr;
  logic                  if_gnt;
  logic                  if_rvalid;
  logic [DATA_WIDTH-1:0] if_rdata;
  logic                  stall_if;

  // Load/store port
  logic                  d_req;
  logic                  d_we;
  logic [BUS_WIDTH-1:0]  d_addr;
  logic [DATA_WIDTH-1:0] d_wdata;
  logic [BE_WIDTH-1:0]   d_be;
  logic                  d_gnt;
  logic                  d_rvalid;
  logic [DATA_WIDTH-1:0] d_rdata;

  // Shared memory port
  logic                  mem_en;
  logic                  mem_we;
  logic [BE_WIDTH-1:0]   mem_be;
  logic [BUS_WIDTH-1:0]  mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;

  modport slave (
    input  if_req, if_addr,
    output if_gnt, if_rvalid, if_rdata, stall_if,
    input  d_req, d_we, d_addr, d_wdata, d_be,
    output d_gnt, d_rvalid, d_rdata,
    output mem_en, mem_we, mem_be, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output if_req, if_addr,
    input  if_gnt, if_rvalid, if_rdata, stall_if,
    output d_req, d_we, d_addr, d_wdata, d_be,
    input  d_gnt, d_rvalid, d_rdata,
    input  mem_en, mem_we, mem_be, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface
`default_nettype wire

// File: rtl/core_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : core_mem_arbiter
// Description : Shares one single-ported synchronous memory (1-cycle read
//               latency, fully pipelined) between the instruction-fetch port
//               and the load/store port. One grant per cycle, data wins ties
//               except when the fetch has waited MAX_DATA_BURST data grants.
//               A registered return state steers each read word back to the
//               port that issued it.
// Ports       : clk  - rising-edge clock
//               rst  - synchronous active-high reset
//               bus  - core_mem_arbiter_if.slave (fetch, data and memory ports)
// Parameters  : BUS_WIDTH      - address width
//               DATA_WIDTH     - data width (byte enables DATA_WIDTH/8)
//               MAX_DATA_BURST - data grants tolerated while a fetch waits
//                                (1..15)
// Revision    : 1.0 - initial release
// ============================================================================
module core_mem_arbiter #(
  parameter int BUS_WIDTH      = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int MAX_DATA_BURST = 4
) (
  input  logic               clk,
  input  logic               rst,
  core_mem_arbiter_if.slave  bus
);

  localparam int         BE_WIDTH    = DATA_WIDTH / 8;
  localparam logic [3:0] c_MAX_BURST = 4'(MAX_DATA_BURST);

  // --------------------------------------------------------------------------
  // Return state: which port owns the word arriving on mem_rdata this cycle
  // --------------------------------------------------------------------------
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RD_IF = 2'd1,
    ST_RD_D  = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [3:0]            r_starve_cnt;
  logic [3:0]            w_starve_nxt;

  logic                  w_starved;
  logic                  w_if_gnt;
  logic                  w_d_gnt;
  logic                  w_d_write;

  logic                  w_mem_en;
  logic                  w_mem_we;
  logic [BE_WIDTH-1:0]   w_mem_be;
  logic [BUS_WIDTH-1:0]  w_mem_addr;
  logic [DATA_WIDTH-1:0] w_mem_wdata;

  logic                  w_if_rvalid;
  logic                  w_d_rvalid;

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_starve_cnt <= 4'd0;
    end else begin
      r_state      <= w_state_nxt;
      r_starve_cnt <= w_starve_nxt;
    end
  end

  assign w_starved = (r_starve_cnt == c_MAX_BURST);

  // --------------------------------------------------------------------------
  // Grant, starvation counter and return-state next values
  // --------------------------------------------------------------------------
  always_comb begin
    w_if_gnt     = 1'b0;
    w_d_gnt      = 1'b0;
    w_starve_nxt = r_starve_cnt;
    w_state_nxt  = ST_IDLE;

    // Grants are suppressed entirely during reset so nothing reaches memory.
    if (!rst) begin
      // Data wins a tie unless the waiting fetch has used up its patience.
      if (bus.d_req && !(bus.if_req && w_starved)) begin
        w_d_gnt = 1'b1;
      end else if (bus.if_req) begin
        w_if_gnt = 1'b1;
      end
    end

    // The counter only measures an unbroken wait: any cycle without a fetch
    // request, or a fetch grant, starts the count over.
    if (!bus.if_req || w_if_gnt) begin
      w_starve_nxt = 4'd0;
    end else if (w_d_gnt && !w_starved) begin
      w_starve_nxt = r_starve_cnt + 4'd1;
    end

    // Writes return nothing, so they leave the return path idle.
    if (w_if_gnt) begin
      w_state_nxt = ST_RD_IF;
    end else if (w_d_gnt && !bus.d_we) begin
      w_state_nxt = ST_RD_D;
    end
  end

  // --------------------------------------------------------------------------
  // Memory request mux; every field is zero when no access is issued
  // --------------------------------------------------------------------------
  assign w_d_write = w_d_gnt && bus.d_we;

  always_comb begin
    w_mem_en    = w_if_gnt | w_d_gnt;
    w_mem_we    = w_d_write;
    w_mem_be    = '0;
    w_mem_addr  = '0;
    w_mem_wdata = '0;

    if (w_d_gnt) begin
      w_mem_addr  = bus.d_addr;
      w_mem_wdata = bus.d_wdata;
      w_mem_be    = w_d_write ? bus.d_be : '1;
    end else if (w_if_gnt) begin
      w_mem_addr  = bus.if_addr;
      w_mem_be    = '1;
    end
  end

  assign bus.if_gnt    = w_if_gnt;
  assign bus.d_gnt     = w_d_gnt;
  assign bus.stall_if  = bus.if_req && !w_if_gnt && !rst;

  assign bus.mem_en    = w_mem_en;
  assign bus.mem_we    = w_mem_we;
  assign bus.mem_be    = w_mem_be;
  assign bus.mem_addr  = w_mem_addr;
  assign bus.mem_wdata = w_mem_wdata;

  // --------------------------------------------------------------------------
  // Read return routing. Masking with rst drops a read that was granted just
  // before reset, so its data never reaches either port.
  // --------------------------------------------------------------------------
  assign w_if_rvalid   = (r_state == ST_RD_IF) && !rst;
  assign w_d_rvalid    = (r_state == ST_RD_D)  && !rst;

  assign bus.if_rvalid = w_if_rvalid;
  assign bus.d_rvalid  = w_d_rvalid;
  assign bus.if_rdata  = w_if_rvalid ? bus.mem_rdata : '0;
  assign bus.d_rdata   = w_d_rvalid  ? bus.mem_rdata : '0;

endmodule
`default_nettype wire

// File: tb/tb_core_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_core_mem_arbiter
// Description : Directed self-checking bench for core_mem_arbiter with a
//               small 1-cycle-latency byte-writable memory model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_core_mem_arbiter;

  localparam int BUS_WIDTH      = 32;
  localparam int DATA_WIDTH     = 32;
  localparam int MAX_DATA_BURST = 4;

  logic clk;
  logic rst;

  int n_tests;
  int n_fail;

  core_mem_arbiter_if #(.BUS_WIDTH(BUS_WIDTH), .DATA_WIDTH(DATA_WIDTH)) bus ();

  core_mem_arbiter #(
    .BUS_WIDTH      (BUS_WIDTH),
    .DATA_WIDTH     (DATA_WIDTH),
    .MAX_DATA_BURST (MAX_DATA_BURST)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: 256 words, word index = addr[9:2]
  logic [31:0] mem [0:255];

  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) begin
        for (int b = 0; b < 4; b++) begin
          if (bus.mem_be[b]) mem[bus.mem_addr[9:2]][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
        end
      end else begin
        bus.mem_rdata <= mem[bus.mem_addr[9:2]];
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.if_req  = 1'b0;
    bus.if_addr = '0;
    bus.d_req   = 1'b0;
    bus.d_we    = 1'b0;
    bus.d_addr  = '0;
    bus.d_wdata = '0;
    bus.d_be    = '0;
  endtask

  logic [9:0]  exp_if_pat;
  logic [31:0] exp_addr;

  initial begin
    n_tests = 0;
    n_fail  = 0;

    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[8'h00] = 32'h00000013;   // 0x000
    mem[8'h01] = 32'h00000013;   // 0x004
    mem[8'h02] = 32'h00000013;   // 0x008
    mem[8'h03] = 32'h00A00093;   // 0x00C
    mem[8'h04] = 32'h11111111;   // 0x010
    mem[8'h05] = 32'h22222222;   // 0x014
    mem[8'h06] = 32'h33333333;   // 0x018
    mem[8'h08] = 32'h44444444;   // 0x020
    mem[8'h09] = 32'h55555555;   // 0x024
    mem[8'h0A] = 32'h66666666;   // 0x028
    mem[8'h40] = 32'h12345678;   // 0x100
    mem[8'hC0] = 32'hCAFEF00D;   // 0x300
    bus.mem_rdata = '0;

    // ---------------- Reset: requests present, everything forced low
    rst = 1'b1;
    idle_inputs();
    tick();
    bus.if_req = 1'b1;
    bus.d_req  = 1'b1;
    #1;
    chk1 ("rst_if_gnt",   bus.if_gnt,   1'b0);
    chk1 ("rst_d_gnt",    bus.d_gnt,    1'b0);
    chk1 ("rst_stall",    bus.stall_if, 1'b0);
    chk1 ("rst_mem_en",   bus.mem_en,   1'b0);
    chk32("rst_mem_addr", bus.mem_addr, 32'h0);
    chk32("rst_mem_be",   32'(bus.mem_be), 32'h0);
    chk1 ("rst_if_rv",    bus.if_rvalid, 1'b0);
    chk1 ("rst_d_rv",     bus.d_rvalid,  1'b0);
    tick();
    rst = 1'b0;
    idle_inputs();
    tick();

    // ---------------- Fetch only: 0x0, 0x4, 0x8
    bus.if_req = 1'b1; bus.if_addr = 32'h0; #1;
    chk1 ("f0_gnt",   bus.if_gnt,   1'b1);
    chk32("f0_addr",  bus.mem_addr, 32'h0);
    chk1 ("f0_stall", bus.stall_if, 1'b0);
    chk1 ("f0_rv",    bus.if_rvalid, 1'b0);
    tick();
    bus.if_addr = 32'h4; #1;
    chk1 ("f1_gnt",   bus.if_gnt,   1'b1);
    chk32("f1_addr",  bus.mem_addr, 32'h4);
    chk1 ("f1_rv",    bus.if_rvalid, 1'b1);
    chk32("f1_rdata", bus.if_rdata, 32'h00000013);
    tick();
    bus.if_addr = 32'h8; #1;
    chk1 ("f2_gnt",   bus.if_gnt,   1'b1);
    chk32("f2_addr",  bus.mem_addr, 32'h8);
    chk1 ("f2_rv",    bus.if_rvalid, 1'b1);
    chk32("f2_rdata", bus.if_rdata, 32'h00000013);
    chk1 ("f2_stall", bus.stall_if, 1'b0);
    tick();
    idle_inputs(); #1;
    chk1 ("f3_rv",     bus.if_rvalid, 1'b1);
    chk32("f3_rdata",  bus.if_rdata,  32'h00000013);
    chk1 ("f3_mem_en", bus.mem_en,    1'b0);
    chk32("f3_addr",   bus.mem_addr,  32'h0);
    tick();

    // ---------------- Contention read
    bus.if_req = 1'b1; bus.if_addr = 32'hC;
    bus.d_req  = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h100; #1;
    chk1 ("c0_d_gnt",  bus.d_gnt,    1'b1);
    chk1 ("c0_if_gnt", bus.if_gnt,   1'b0);
    chk1 ("c0_stall",  bus.stall_if, 1'b1);
    chk32("c0_addr",   bus.mem_addr, 32'h100);
    chk1 ("c0_we",     bus.mem_we,   1'b0);
    chk32("c0_be",     32'(bus.mem_be), 32'hF);
    tick();
    bus.d_req = 1'b0; #1;
    chk1 ("c1_d_rv",    bus.d_rvalid,  1'b1);
    chk32("c1_d_rdata", bus.d_rdata,   32'h12345678);
    chk1 ("c1_if_rv",   bus.if_rvalid, 1'b0);
    chk32("c1_if_rdata",bus.if_rdata,  32'h0);
    chk1 ("c1_if_gnt",  bus.if_gnt,    1'b1);
    chk32("c1_addr",    bus.mem_addr,  32'hC);
    tick();
    idle_inputs(); #1;
    chk1 ("c2_if_rv",   bus.if_rvalid, 1'b1);
    chk32("c2_if_rdata",bus.if_rdata,  32'h00A00093);
    chk1 ("c2_d_rv",    bus.d_rvalid,  1'b0);
    tick();

    // ---------------- Starvation guard: D D D D I D D D D I
    exp_if_pat = 10'b10_0001_0000;   // bit c set => fetch wins cycle c
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h100;
    bus.if_req = 1'b1; bus.if_addr = 32'h10;
    for (int c = 0; c < 10; c++) begin
      #1;
      exp_addr = exp_if_pat[c] ? bus.if_addr : 32'h100;
      chk1 ($sformatf("sv%0d_if_gnt", c), bus.if_gnt, exp_if_pat[c]);
      chk1 ($sformatf("sv%0d_d_gnt",  c), bus.d_gnt,  ~exp_if_pat[c]);
      chk32($sformatf("sv%0d_addr",   c), bus.mem_addr, exp_addr);
      tick();
      if (c == 4) bus.if_addr = 32'h14;
    end
    idle_inputs(); #1;
    chk1 ("sv_end_if_rv",   bus.if_rvalid, 1'b1);
    chk32("sv_end_if_rdata",bus.if_rdata,  32'h22222222);
    chk1 ("sv_end_d_rv",    bus.d_rvalid,  1'b0);
    tick();

    // ---------------- Write while a fetch read returns
    bus.if_req = 1'b1; bus.if_addr = 32'h18; #1;
    chk1 ("w0_if_gnt", bus.if_gnt, 1'b1);
    tick();
    idle_inputs();
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h200;
    bus.d_wdata = 32'hDEADBEEF; bus.d_be = 4'b0011; #1;
    chk1 ("w1_d_gnt",    bus.d_gnt,     1'b1);
    chk1 ("w1_mem_en",   bus.mem_en,    1'b1);
    chk1 ("w1_mem_we",   bus.mem_we,    1'b1);
    chk32("w1_mem_be",   32'(bus.mem_be), 32'h3);
    chk32("w1_mem_addr", bus.mem_addr,  32'h200);
    chk32("w1_mem_wdata",bus.mem_wdata, 32'hDEADBEEF);
    chk1 ("w1_if_rv",    bus.if_rvalid, 1'b1);
    chk32("w1_if_rdata", bus.if_rdata,  32'h33333333);
    tick();
    idle_inputs(); #1;
    chk1 ("w2_d_rv",  bus.d_rvalid,  1'b0);
    chk1 ("w2_if_rv", bus.if_rvalid, 1'b0);
    tick();
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h200; #1;
    chk1 ("w3_d_gnt", bus.d_gnt, 1'b1);
    tick();
    idle_inputs(); #1;
    chk1 ("w4_d_rv",    bus.d_rvalid, 1'b1);
    chk32("w4_d_rdata", bus.d_rdata,  32'h0000BEEF);
    tick();

    // ---------------- Reset in the middle of a data read
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h100; #1;
    chk1 ("r0_d_gnt", bus.d_gnt, 1'b1);
    tick();
    rst = 1'b1;
    idle_inputs();
    bus.if_req = 1'b1; bus.if_addr = 32'h20; #1;
    chk1 ("r1_d_rv",     bus.d_rvalid, 1'b0);
    chk32("r1_d_rdata",  bus.d_rdata,  32'h0);
    chk1 ("r1_if_gnt",   bus.if_gnt,   1'b0);
    chk1 ("r1_stall",    bus.stall_if, 1'b0);
    chk1 ("r1_mem_en",   bus.mem_en,   1'b0);
    chk32("r1_mem_addr", bus.mem_addr, 32'h0);
    tick();
    rst = 1'b0; #1;
    chk1 ("r2_if_gnt",   bus.if_gnt,   1'b1);
    chk1 ("r2_d_rv",     bus.d_rvalid, 1'b0);
    chk32("r2_mem_addr", bus.mem_addr, 32'h20);
    tick();
    idle_inputs(); #1;
    chk1 ("r3_if_rv",    bus.if_rvalid, 1'b1);
    chk32("r3_if_rdata", bus.if_rdata,  32'h44444444);
    tick();

    // ---------------- Interleave: fetch, data read, fetch
    bus.if_req = 1'b1; bus.if_addr = 32'h24; #1;
    chk1 ("i0_if_gnt", bus.if_gnt, 1'b1);
    tick();
    idle_inputs();
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h300; #1;
    chk1 ("i1_d_gnt",    bus.d_gnt,     1'b1);
    chk1 ("i1_if_rv",    bus.if_rvalid, 1'b1);
    chk32("i1_if_rdata", bus.if_rdata,  32'h55555555);
    chk1 ("i1_d_rv",     bus.d_rvalid,  1'b0);
    tick();
    idle_inputs();
    bus.if_req = 1'b1; bus.if_addr = 32'h28; #1;
    chk1 ("i2_if_gnt",   bus.if_gnt,    1'b1);
    chk1 ("i2_d_rv",     bus.d_rvalid,  1'b1);
    chk32("i2_d_rdata",  bus.d_rdata,   32'hCAFEF00D);
    chk1 ("i2_if_rv",    bus.if_rvalid, 1'b0);
    tick();
    idle_inputs(); #1;
    chk1 ("i3_if_rv",    bus.if_rvalid, 1'b1);
    chk32("i3_if_rdata", bus.if_rdata,  32'h66666666);
    chk1 ("i3_d_rv",     bus.d_rvalid,  1'b0);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
